// File: rtl/baud_gen_frac.sv
// Fractional UART baud generator: oversample tick, baud tick and square baud clock
// from a runtime-programmable integer + fractional divisor.
module baud_gen_frac #(
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_W     = 4,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DEF_DIV    = 1,
    parameter int unsigned DEF_FRAC   = 0
) (
    input  logic                          clk1_8m,
    input  logic                          rst,
    input  logic                          en,
    input  logic [DIV_W-1:0]              div_int_in,
    input  logic [FRAC_W-1:0]             div_frac_in,
    input  logic                          div_load,
    output logic                          div_ack,
    output logic                          tick_os,
    output logic                          tick_baud,
    output logic                          clk_baud,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

    localparam int unsigned OS_W = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0]  DEF_DIV_EFF = (DEF_DIV == 0) ? DIV_W'(1) : DIV_W'(DEF_DIV);
    localparam logic [FRAC_W-1:0] DEF_FRAC_V  = FRAC_W'(DEF_FRAC);
    localparam logic [OS_W-1:0]   PHASE_LAST  = OS_W'(OVERSAMPLE - 1);

    // A zero divisor is stored as 1, so the reload value div-1 never underflows.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [DIV_W-1:0]  sh_div_q, sh_div_d;
    logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
    logic              pend_q, pend_d;
    logic              ack_q, ack_d;
    logic              tick_os_q, tick_os_d;
    logic              tick_baud_q, tick_baud_d;
    logic              clk_baud_q, clk_baud_d;
    logic [OS_W-1:0]   phase_q, phase_d;
    logic [FRAC_W:0]   sum;
    logic [DIV_W:0]    p_full;

    always_ff @(posedge clk1_8m) begin
        if (rst) begin
            cnt_q       <= DEF_DIV_EFF - DIV_W'(1);
            div_q       <= DEF_DIV_EFF;
            frac_q      <= DEF_FRAC_V;
            acc_q       <= '0;
            sh_div_q    <= DEF_DIV_EFF;
            sh_frac_q   <= DEF_FRAC_V;
            pend_q      <= 1'b0;
            ack_q       <= 1'b0;
            tick_os_q   <= 1'b0;
            tick_baud_q <= 1'b0;
            clk_baud_q  <= 1'b0;
            phase_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            frac_q      <= frac_d;
            acc_q       <= acc_d;
            sh_div_q    <= sh_div_d;
            sh_frac_q   <= sh_frac_d;
            pend_q      <= pend_d;
            ack_q       <= ack_d;
            tick_os_q   <= tick_os_d;
            tick_baud_q <= tick_baud_d;
            clk_baud_q  <= clk_baud_d;
            phase_q     <= phase_d;
        end
    end

    // Fractional carry lengthens the next interval by one cycle.
    assign sum    = {1'b0, acc_q} + {1'b0, frac_q};
    assign p_full = {1'b0, div_q} + (DIV_W+1)'(sum[FRAC_W]);

    always_comb begin
        cnt_d       = cnt_q;
        div_d       = div_q;
        frac_d      = frac_q;
        acc_d       = acc_q;
        sh_div_d    = sh_div_q;
        sh_frac_d   = sh_frac_q;
        pend_d      = pend_q;
        ack_d       = 1'b0;
        tick_os_d   = 1'b0;
        tick_baud_d = 1'b0;
        phase_d     = phase_q;

        if (!en) begin
            acc_d = '0;
            if (div_load) begin
                div_d  = eff_div(div_int_in);
                frac_d = div_frac_in;
                pend_d = 1'b0;
                ack_d  = 1'b1;
            end else if (pend_q) begin
                div_d  = sh_div_q;
                frac_d = sh_frac_q;
                pend_d = 1'b0;
                ack_d  = 1'b1;
            end
            cnt_d = div_d - DIV_W'(1);
        end else begin
            // Shadow capture; a load on a reload cycle waits for the next one.
            if (div_load) begin
                sh_div_d  = eff_div(div_int_in);
                sh_frac_d = div_frac_in;
                pend_d    = 1'b1;
            end
            if (cnt_q == '0) begin
                tick_os_d   = 1'b1;
                tick_baud_d = (phase_q == PHASE_LAST);
                phase_d     = phase_q + OS_W'(1);
                if (pend_q) begin
                    div_d  = sh_div_q;
                    frac_d = sh_frac_q;
                    acc_d  = '0;
                    cnt_d  = sh_div_q - DIV_W'(1);
                    ack_d  = 1'b1;
                    if (!div_load) begin
                        pend_d = 1'b0;
                    end
                end else begin
                    acc_d = sum[FRAC_W-1:0];
                    cnt_d = DIV_W'(p_full - (DIV_W+1)'(1));
                end
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end

        clk_baud_d = phase_d[OS_W-1];
    end

    assign div_ack   = ack_q;
    assign tick_os   = tick_os_q;
    assign tick_baud = tick_baud_q;
    assign clk_baud  = clk_baud_q;
    assign os_phase  = phase_q;

endmodule
